// File: rtl/pixel_word_packer.sv
// Packs a narrow AXI4-Stream pixel stream into wide words with keep masks.
// s_axis_*: pixel in (tuser=eol, tlast=eof); m_axis_*: packed word out; clear_err/line_len_err: sticky line-length flag.
module pixel_word_packer #(
  parameter int PIXEL_WIDTH           = 8,
  parameter int PIXELS_PER_WORD       = 4,
  parameter int LANE_LOG2             = 2,
  parameter int IMAGE_WIDTH_SIZE      = 512,
  parameter int IMAGE_WIDTH_LOG2_SIZE = 9
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   s_axis_tvalid,
  input  logic [PIXEL_WIDTH-1:0]                 s_axis_tdata,
  output logic                                   s_axis_tready,
  input  logic                                   s_axis_tuser,
  input  logic                                   s_axis_tlast,
  output logic                                   m_axis_tvalid,
  output logic [PIXEL_WIDTH*PIXELS_PER_WORD-1:0] m_axis_tdata,
  output logic [PIXELS_PER_WORD-1:0]             m_axis_tkeep,
  input  logic                                   m_axis_tready,
  output logic                                   m_axis_tuser,
  output logic                                   m_axis_tlast,
  input  logic                                   clear_err,
  output logic                                   line_len_err
);

  localparam int PW  = PIXEL_WIDTH;
  localparam int PPW = PIXELS_PER_WORD;
  localparam int CW  = IMAGE_WIDTH_LOG2_SIZE + 1;

  localparam logic [LANE_LOG2-1:0] LAST_LANE = '1;
  localparam logic [LANE_LOG2-1:0] LANE_ONE  = 1;
  localparam logic [CW-1:0]        CNT_ONE   = 1;
  localparam logic [CW:0]          LEN_ONE   = 1;
  localparam logic [CW:0]          EXP_LEN   = IMAGE_WIDTH_SIZE[CW:0];

  logic [LANE_LOG2-1:0] lane;
  logic [PW-1:0]        acc [PPW-1];
  logic [CW-1:0]        pcnt;

  logic              accept;
  logic              line_end;
  logic              complete;
  logic [PW*PPW-1:0] word_d;
  logic [PPW-1:0]    keep_d;
  logic [CW:0]       line_len;

  assign s_axis_tready = !m_axis_tvalid || m_axis_tready;
  assign accept        = s_axis_tvalid && s_axis_tready;
  assign line_end      = s_axis_tuser || s_axis_tlast;
  assign complete      = accept && (lane == LAST_LANE || line_end);
  assign line_len      = {1'b0, pcnt} + LEN_ONE;

  // Lanes below the current one come from the accumulator, the current
  // lane takes the incoming pixel, lanes above are zero-filled.
  always_comb begin
    word_d = '0;
    keep_d = '0;
    for (int i = 0; i < PPW - 1; i++) begin
      if (LANE_LOG2'(i) < lane)
        word_d[i*PW +: PW] = acc[i];
      else if (LANE_LOG2'(i) == lane)
        word_d[i*PW +: PW] = s_axis_tdata;
      keep_d[i] = (LANE_LOG2'(i) <= lane);
    end
    if (lane == LAST_LANE) begin
      word_d[(PPW-1)*PW +: PW] = s_axis_tdata;
      keep_d[PPW-1]            = 1'b1;
    end
  end

  // Pixel storage needs no reset: lanes at or above `lane` are never read.
  always_ff @(posedge clk) begin
    for (int i = 0; i < PPW - 1; i++)
      if (accept && !complete && lane == LANE_LOG2'(i))
        acc[i] <= s_axis_tdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lane          <= '0;
      pcnt          <= '0;
      line_len_err  <= 1'b0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tuser  <= 1'b0;
      m_axis_tlast  <= 1'b0;
    end else begin
      if (complete) begin
        lane          <= '0;
        m_axis_tvalid <= 1'b1;
        m_axis_tdata  <= word_d;
        m_axis_tkeep  <= keep_d;
        m_axis_tuser  <= s_axis_tuser;
        m_axis_tlast  <= s_axis_tlast;
      end else begin
        if (accept)
          lane <= lane + LANE_ONE;
        if (m_axis_tvalid && m_axis_tready)
          m_axis_tvalid <= 1'b0;
      end

      if (accept) begin
        if (line_end)
          pcnt <= '0;
        else if (pcnt != '1)
          pcnt <= pcnt + CNT_ONE;
      end

      // A new error outranks a same-cycle clear.
      if (accept && line_end && line_len != EXP_LEN)
        line_len_err <= 1'b1;
      else if (clear_err)
        line_len_err <= 1'b0;
    end
  end

endmodule
